// File: rtl/load_align_unit.sv
// rtl/load_align_unit.sv - sequential load unit: aligned word reads, byte extraction, sign/zero extension
//
// Accepts one load at a time, issues one aligned memory read (two when the
// access spans a memory word and splitting is enabled), then shifts and
// extends the addressed bytes according to i_fun3.
//
// Ports:
//   i_clk         clock, rising edge
//   i_rst         asynchronous active-high reset
//   i_req_valid   load request present
//   o_req_ready   unit can accept (IDLE only, low while reset is held)
//   i_fun3        load type: LB/LH/LW/LD/LBU/LHU/LWU
//   i_addr        byte address
//   o_mem_req     one-cycle read strobe
//   o_mem_addr    word-aligned read address
//   i_mem_rdata   read data, little-endian
//   i_mem_rvalid  read data valid
//   o_resp_valid  one-cycle result pulse
//   o_resp_data   extended load result, zero on fault
//   o_resp_fault  misaligned access (splitting disabled) or illegal i_fun3

module load_align_unit #(
    parameter int XLEN             = 32,
    parameter int ADDR_W           = 32,
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic [2:0]        i_fun3,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              o_mem_req,
    output logic [ADDR_W-1:0] o_mem_addr,
    input  logic [XLEN-1:0]   i_mem_rdata,
    input  logic              i_mem_rvalid,
    output logic              o_resp_valid,
    output logic [XLEN-1:0]   o_resp_data,
    output logic              o_resp_fault
);

    localparam int BYTES = XLEN / 8;
    localparam int OFF_W = $clog2(BYTES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE0,
        S_WAIT0,
        S_ISSUE1,
        S_WAIT1,
        S_RESP
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;

    logic [2:0]              r_fun3;
    logic [ADDR_W-1:OFF_W]   r_word_addr;
    logic [OFF_W-1:0]        r_offset;
    logic                    r_span;
    logic [XLEN-1:0]         r_word0;
    logic [XLEN-1:0]         r_resp_data;
    logic                    r_resp_fault;

    // Request decode (combinational on the incoming request)
    logic                    w_accept;
    logic [3:0]              w_req_size;
    logic [OFF_W-1:0]        w_req_offset;
    logic [4:0]              w_span_sum;
    logic                    w_req_span;
    logic                    w_illegal;
    logic                    w_misaligned;
    logic                    w_req_fault;

    // Data path
    logic [3:0]              w_size;
    logic [ADDR_W-1:0]       w_aligned;
    logic [2*XLEN-1:0]       w_pair;
    logic [OFF_W+2:0]        w_shamt;
    logic [XLEN-1:0]         w_low;
    logic [6:0]              w_nbits;
    logic [XLEN-1:0]         w_mask;
    logic                    w_sext;
    logic                    w_sign;
    logic [XLEN-1:0]         w_result;

    function automatic logic [3:0] size_of(input logic [1:0] f);
        case (f)
            2'b00:   return 4'd1;
            2'b01:   return 4'd2;
            2'b10:   return 4'd4;
            default: return 4'd8;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    always_comb begin
        w_req_size   = size_of(i_fun3[1:0]);
        w_req_offset = i_addr[OFF_W-1:0];
        w_span_sum   = 5'(w_req_offset) + 5'(w_req_size);
        w_req_span   = (w_span_sum > 5'(BYTES));
        // LD and LWU do not exist on a 32-bit datapath
        w_illegal    = (i_fun3 == 3'b111) ||
                       ((XLEN == 32) && ((i_fun3 == 3'b011) || (i_fun3 == 3'b110)));
        // Natural alignment: low address bits under the access size must be zero
        w_misaligned = ((4'({1'b0, i_addr[2:0]}) & (w_req_size - 4'd1)) != 4'd0);
        w_req_fault  = w_illegal || (!ALLOW_MISALIGNED && w_misaligned);
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and control outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        o_req_ready  = 1'b0;
        o_mem_req    = 1'b0;
        o_mem_addr   = '0;
        o_resp_valid = 1'b0;
        w_accept     = 1'b0;

        case (r_state)
            S_IDLE: begin
                // Ready is suppressed while reset is held so no request can slip in
                o_req_ready = !i_rst;
                if (i_req_valid && !i_rst) begin
                    w_accept     = 1'b1;
                    w_state_next = w_req_fault ? S_RESP : S_ISSUE0;
                end
            end
            S_ISSUE0: begin
                o_mem_req    = 1'b1;
                o_mem_addr   = w_aligned;
                w_state_next = S_WAIT0;
            end
            S_WAIT0: begin
                if (i_mem_rvalid) begin
                    w_state_next = r_span ? S_ISSUE1 : S_RESP;
                end
            end
            S_ISSUE1: begin
                o_mem_req    = 1'b1;
                // Natural ADDR_W-bit wrap at the top of the address space
                o_mem_addr   = w_aligned + ADDR_W'(BYTES);
                w_state_next = S_WAIT1;
            end
            S_WAIT1: begin
                if (i_mem_rvalid) begin
                    w_state_next = S_RESP;
                end
            end
            S_RESP: begin
                o_resp_valid = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Data path: concatenate, shift, mask, extend
    // ------------------------------------------------------------------
    always_comb begin
        w_size    = size_of(r_fun3[1:0]);
        w_aligned = {r_word_addr, {OFF_W{1'b0}}};
        // The second word only contributes when the access spans; in WAIT0
        // the upper half is zero so the same shifter serves both cases.
        w_pair    = (r_state == S_WAIT1) ? {i_mem_rdata, r_word0}
                                         : {{XLEN{1'b0}}, i_mem_rdata};
        w_shamt   = {r_offset, 3'b000};
        w_low     = XLEN'(w_pair >> w_shamt);
        w_nbits   = {w_size, 3'b000};
        // A shift by the full width yields zero, so LD (and LW on RV32) keeps every bit
        w_mask    = ~({XLEN{1'b1}} << w_nbits);
        w_sext    = !r_fun3[2] && (r_fun3[1:0] != 2'b11);
        case (r_fun3[1:0])
            2'b00:   w_sign = w_low[7];
            2'b01:   w_sign = w_low[15];
            2'b10:   w_sign = w_low[31];
            default: w_sign = 1'b0;
        endcase
        w_result = (w_low & w_mask) | ((w_sext && w_sign) ? ~w_mask : {XLEN{1'b0}});
    end

    // ------------------------------------------------------------------
    // Request capture, word latch and registered response
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_fun3       <= '0;
            r_word_addr  <= '0;
            r_offset     <= '0;
            r_span       <= 1'b0;
            r_word0      <= '0;
            r_resp_data  <= '0;
            r_resp_fault <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_fun3       <= i_fun3;
                        r_word_addr  <= i_addr[ADDR_W-1:OFF_W];
                        r_offset     <= w_req_offset;
                        r_span       <= w_req_span;
                        r_resp_data  <= '0;
                        r_resp_fault <= w_req_fault;
                    end
                end
                S_WAIT0: begin
                    if (i_mem_rvalid) begin
                        if (r_span) begin
                            r_word0 <= i_mem_rdata;
                        end else begin
                            r_resp_data <= w_result;
                        end
                    end
                end
                S_WAIT1: begin
                    if (i_mem_rvalid) begin
                        r_resp_data <= w_result;
                    end
                end
                S_RESP: begin
                    r_resp_data  <= '0;
                    r_resp_fault <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    assign o_resp_data  = r_resp_data;
    assign o_resp_fault = r_resp_fault;

endmodule

// File: tb/tb_load_align_unit.sv
// tb/tb_load_align_unit.sv - directed self-checking bench for load_align_unit

module tb_load_align_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic [2:0]  fun3 = 3'b000;
    logic [31:0] addr = 32'h0;
    logic [1:0]  sel = 2'd0;
    int          lat = 1;
    int          cnt = 0;
    logic [31:0] pa = 32'h0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Instance A: RV32, split spanning loads
    logic        rdy_a, mreq_a, rvld_a, flt_a;
    logic [31:0] maddr_a, rdat_a;
    // Instance B: RV32, fault on misaligned
    logic        rdy_b, mreq_b, rvld_b, flt_b;
    logic [31:0] maddr_b, rdat_b;
    // Instance C: RV64, split spanning loads
    logic        rdy_c, mreq_c, rvld_c, flt_c;
    logic [31:0] maddr_c;
    logic [63:0] rdat_c;

    logic        m_req, m_rvalid, o_ready, o_rvalid, o_fault;
    logic [31:0] m_addr;
    logic [63:0] m_rdata, o_data;

    load_align_unit #(.XLEN(32), .ADDR_W(32), .ALLOW_MISALIGNED(1'b1)) u_a (
        .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid && sel == 2'd0), .o_req_ready(rdy_a),
        .i_fun3(fun3), .i_addr(addr), .o_mem_req(mreq_a), .o_mem_addr(maddr_a),
        .i_mem_rdata(m_rdata[31:0]), .i_mem_rvalid(m_rvalid && sel == 2'd0),
        .o_resp_valid(rvld_a), .o_resp_data(rdat_a), .o_resp_fault(flt_a));

    load_align_unit #(.XLEN(32), .ADDR_W(32), .ALLOW_MISALIGNED(1'b0)) u_b (
        .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid && sel == 2'd1), .o_req_ready(rdy_b),
        .i_fun3(fun3), .i_addr(addr), .o_mem_req(mreq_b), .o_mem_addr(maddr_b),
        .i_mem_rdata(m_rdata[31:0]), .i_mem_rvalid(m_rvalid && sel == 2'd1),
        .o_resp_valid(rvld_b), .o_resp_data(rdat_b), .o_resp_fault(flt_b));

    load_align_unit #(.XLEN(64), .ADDR_W(32), .ALLOW_MISALIGNED(1'b1)) u_c (
        .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid && sel == 2'd2), .o_req_ready(rdy_c),
        .i_fun3(fun3), .i_addr(addr), .o_mem_req(mreq_c), .o_mem_addr(maddr_c),
        .i_mem_rdata(m_rdata), .i_mem_rvalid(m_rvalid && sel == 2'd2),
        .o_resp_valid(rvld_c), .o_resp_data(rdat_c), .o_resp_fault(flt_c));

    function automatic logic [63:0] memdata(input logic [1:0] s, input logic [31:0] a);
        if (s == 2'd2) begin
            return (a == 32'h100) ? 64'h11223344_8899AABB : 64'h5A5A5A5A_5A5A5A5A;
        end
        case (a)
            32'h100: return 64'h8899AABB;
            32'h104: return 64'h11223344;
            default: return 64'h5A5A5A5A;
        endcase
    endfunction

    always_comb begin
        case (sel)
            2'd1:    begin m_req = mreq_b; m_addr = maddr_b; o_ready = rdy_b; o_rvalid = rvld_b; o_data = {32'h0, rdat_b}; o_fault = flt_b; end
            2'd2:    begin m_req = mreq_c; m_addr = maddr_c; o_ready = rdy_c; o_rvalid = rvld_c; o_data = rdat_c;           o_fault = flt_c; end
            default: begin m_req = mreq_a; m_addr = maddr_a; o_ready = rdy_a; o_rvalid = rvld_a; o_data = {32'h0, rdat_a}; o_fault = flt_a; end
        endcase
        m_rvalid = (cnt == 1);
        m_rdata  = memdata(sel, pa);
    end

    // Memory model: answers lat cycles after the strobe; ignores reset on purpose
    always @(posedge clk) begin
        if (cnt != 0) cnt <= cnt - 1;
        if (m_req) begin
            pa  <= m_addr;
            cnt <= lat;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic run(input string tag, input logic [2:0] f, input logic [31:0] a,
                       input logic [63:0] exp_d, input logic exp_f, input int exp_lat,
                       input int exp_nreq, input logic [31:0] exp_a0, input logic [31:0] exp_a1);
        int cyc;
        int nreq;
        logic got;
        logic [31:0] a0;
        logic [31:0] a1;
        logic [63:0] d;
        logic flt;
        cyc = 1; nreq = 0; got = 1'b0; a0 = '0; a1 = '0; d = '0; flt = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; fun3 = f; addr = a;
        #1;
        chk({tag, " ready"}, {63'h0, o_ready}, 64'h1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        while (!got && cyc <= 30) begin
            @(negedge clk);
            if (m_req) begin
                nreq++;
                if (nreq == 1) a0 = m_addr; else a1 = m_addr;
            end
            if (o_rvalid) begin
                got = 1'b1; d = o_data; flt = o_fault;
            end else begin
                cyc++;
            end
        end
        chk({tag, " resp_seen"}, {63'h0, got}, 64'h1);
        if (got) begin
            chk({tag, " latency"}, 64'(cyc), 64'(exp_lat));
            chk({tag, " data"}, d, exp_d);
            chk({tag, " fault"}, {63'h0, flt}, {63'h0, exp_f});
            chk({tag, " mem_req_count"}, 64'(nreq), 64'(exp_nreq));
            if (exp_nreq >= 1) chk({tag, " mem_addr0"}, {32'h0, a0}, {32'h0, exp_a0});
            if (exp_nreq >= 2) chk({tag, " mem_addr1"}, {32'h0, a1}, {32'h0, exp_a1});
            @(negedge clk);
            chk({tag, " pulse_end"}, {63'h0, o_rvalid}, 64'h0);
            chk({tag, " data_cleared"}, o_data, 64'h0);
        end
    endtask

    initial begin
        // Reset state
        sel = 2'd0;
        @(negedge clk);
        chk("reset ready", {63'h0, rdy_a}, 64'h0);
        chk("reset mem_req", {63'h0, mreq_a}, 64'h0);
        chk("reset mem_addr", {32'h0, maddr_a}, 64'h0);
        chk("reset resp", {61'h0, rvld_a, flt_a, |rdat_a}, 64'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post-reset ready", {63'h0, rdy_a}, 64'h1);

        // RV32, splitting allowed
        sel = 2'd0; lat = 1;
        run("lb_100",  3'b000, 32'h100, 64'hFFFFFFBB, 1'b0, 3, 1, 32'h100, 32'h0);
        run("lbu_103", 3'b100, 32'h103, 64'h00000088, 1'b0, 3, 1, 32'h100, 32'h0);
        run("lh_102",  3'b001, 32'h102, 64'hFFFF8899, 1'b0, 3, 1, 32'h100, 32'h0);
        run("lw_102_span",  3'b010, 32'h102, 64'h33448899, 1'b0, 5, 2, 32'h100, 32'h104);
        run("lhu_103_span", 3'b101, 32'h103, 64'h00004488, 1'b0, 5, 2, 32'h100, 32'h104);
        run("lw_104",  3'b010, 32'h104, 64'h11223344, 1'b0, 3, 1, 32'h104, 32'h0);

        // RV32, misaligned faults
        sel = 2'd1;
        run("nomis_lw_102", 3'b010, 32'h102, 64'h0, 1'b1, 1, 0, 32'h0, 32'h0);
        run("nomis_lh_100", 3'b001, 32'h100, 64'hFFFFAABB, 1'b0, 3, 1, 32'h100, 32'h0);
        run("illegal_111",  3'b111, 32'h100, 64'h0, 1'b1, 1, 0, 32'h0, 32'h0);
        run("illegal_011",  3'b011, 32'h100, 64'h0, 1'b1, 1, 0, 32'h0, 32'h0);

        // RV64
        sel = 2'd2;
        run("rv64_ld_100",  3'b011, 32'h100, 64'h11223344_8899AABB, 1'b0, 3, 1, 32'h100, 32'h0);
        run("rv64_lwu_104", 3'b110, 32'h104, 64'h00000000_11223344, 1'b0, 3, 1, 32'h100, 32'h0);
        run("rv64_lw_104",  3'b010, 32'h104, 64'h00000000_11223344, 1'b0, 3, 1, 32'h100, 32'h0);
        run("rv64_lw_100",  3'b010, 32'h100, 64'hFFFFFFFF_8899AABB, 1'b0, 3, 1, 32'h100, 32'h0);
        run("rv64_illegal", 3'b111, 32'h100, 64'h0, 1'b1, 1, 0, 32'h0, 32'h0);

        // Memory latency 3
        sel = 2'd0; lat = 3;
        run("lat3_lw_span", 3'b010, 32'h102, 64'h33448899, 1'b0, 9, 2, 32'h100, 32'h104);

        // Reset during WAIT1 (cycle T+6 with latency 3), stale return at T+8
        @(negedge clk);
        req_valid = 1'b1; fun3 = 3'b010; addr = 32'h102;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("midrst ready", {63'h0, rdy_a}, 64'h0);
        chk("midrst mem_req", {63'h0, mreq_a}, 64'h0);
        chk("midrst mem_addr", {32'h0, maddr_a}, 64'h0);
        chk("midrst resp", {61'h0, rvld_a, flt_a, |rdat_a}, 64'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("stale resp_valid", {63'h0, rvld_a}, 64'h0);
            chk("stale ready", {63'h0, rdy_a}, 64'h1);
        end
        lat = 1;
        run("after_rst_lb", 3'b000, 32'h100, 64'hFFFFFFBB, 1'b0, 3, 1, 32'h100, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
